// File: rtl/input_cond_pkg.sv
// input_cond_pkg: channel map and default debounce length shared by the input conditioner.
package input_cond_pkg;
    localparam int NUM_CH           = 10;
    localparam int CH_START         = 0;
    localparam int CH_RST1          = 1;
    localparam int CH_RST2          = 2;
    localparam int CH_RST3          = 3;
    localparam int CH_RST4          = 4;
    localparam int CH_STOP          = 5;
    localparam int CH_A0            = 6;
    localparam int CH_A1            = 7;
    localparam int CH_B0            = 8;
    localparam int CH_B1            = 9;
    localparam int DEFAULT_DEBOUNCE = 50000;
endpackage

// File: rtl/debounce_ch.sv
// debounce_ch: two-flop synchroniser followed by a stability counter; the stable level
// changes only after DEBOUNCE_CYCLES consecutive cycles of disagreement.
module debounce_ch #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic raw_i,
    output logic stable_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stable_q, stable_d;
    logic          diff, done;

    always_comb begin
        diff     = sync_q[1] ^ stable_q;
        done     = diff && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
        stable_d = done ? sync_q[1] : stable_q;
        cnt_d    = (diff && !done) ? cnt_q + CW'(1) : '0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], raw_i};
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable_o = stable_q;
endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: debounces ten raw channels, turns button presses into one-cycle
// pulses and toggles the run enable on each stop/resume press.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
    parameter int BTN_ACTIVE_LOW  = 0
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       start_button_raw_i,
    input  logic [3:0] reset_button_raw_i,
    input  logic       stop_reanudar_raw_i,
    input  logic [3:0] sensor_raw_i,
    output logic       start_pulse_o,
    output logic [3:0] reset_pulse_o,
    output logic       run_o,
    output logic [3:0] sensor_o
);
    logic [NUM_CH-1:0]  raw, stable;
    logic [CH_STOP:0]   prev_q, rise;
    logic               run_q;

    // Only the five push-buttons follow the polarity option; stop and sensors are fixed.
    assign raw = {sensor_raw_i, stop_reanudar_raw_i,
                  {reset_button_raw_i, start_button_raw_i} ^ {5{BTN_ACTIVE_LOW != 0}}};

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch (
            .clk_i    (clk_i),
            .rst_n_i  (rst_n_i),
            .raw_i    (raw[i]),
            .stable_o (stable[i])
        );
    end

    assign rise = stable[CH_STOP:CH_START] & ~prev_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            prev_q <= '0;
            run_q  <= 1'b1;
        end else begin
            prev_q <= stable[CH_STOP:CH_START];
            run_q  <= run_q ^ rise[CH_STOP];
        end
    end

    assign start_pulse_o = rise[CH_START];
    assign reset_pulse_o = rise[CH_RST4:CH_RST1];
    assign run_o         = run_q;
    assign sensor_o      = stable[CH_B1:CH_A0];
endmodule
